// File: rtl/ctrl_pkg.sv
// Shared types and helpers for the control-path arbiters.
// Holds the requester count, the arbiter state encoding and a one-hot decoder.
package ctrl_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters.
// Searches last+1, last+2, last+3, last+4 (mod 4) for the first unmasked request.
module rr_pick4
  import ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         last_i,
  input  logic [NUM_REQ-1:0] mask_i,
  output logic               found_o,
  output logic [1:0]         idx_o
);

  logic [NUM_REQ-1:0] elig;
  logic [1:0]         cand;

  always_comb begin
    elig    = req_i & ~mask_i;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    // k = 4 wraps back to last_i itself, so the previous owner is searched last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_i + 2'(k);
      if (!found_o && elig[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter4.sv
// Round-robin sequencer sharing one memory/resource port among four requesters,
// with an optional watchdog that aborts transactions the resource never finishes.
module mem_port_arbiter4
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               res_ready_i,
  input  logic               res_done_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [1:0]         sel_o,
  output logic               res_valid_o,
  output logic [NUM_REQ-1:0] ack_o,
  output logic               err_o
);

  localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  // Handshake: res_valid_o is high for every ISSUE cycle; res_ready_i is only
  // sampled while res_valid_o is high and moves the transaction to WAIT. res_done_i
  // ends the transaction from WAIT, or from ISSUE when it arrives with res_ready_i.
  arb_state_t         state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;

  logic               busy;
  logic [1:0]         pick_last;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_found;
  logic [1:0]         pick_idx;
  logic               complete;
  logic               timeout;
  logic [CNT_W-1:0]   cnt_inc;

  // While busy the re-pick for back-to-back issue starts after the current owner.
  assign busy      = (state_q != ARB_IDLE);
  assign pick_last = busy ? sel_q : last_q;
  assign pick_mask = busy ? onehot4(sel_q) : '0;

  rr_pick4 u_pick (
    .req_i   (req_i),
    .last_i  (pick_last),
    .mask_i  (pick_mask),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    complete = res_done_i &
               ((state_q == ARB_WAIT) | ((state_q == ARB_ISSUE) & res_ready_i));
    timeout  = WD_EN && (cnt_q == TO_LAST) && !complete;
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    ack_o    = complete ? onehot4(sel_q) : '0;

    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_ISSUE;
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ARB_ISSUE, ARB_WAIT: begin
        if (complete) begin
          last_d = sel_q;
          if (pick_found) begin
            state_d = ARB_ISSUE;
            sel_d   = pick_idx;
            cnt_d   = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (timeout) begin
          // Abort: the victim keeps sel_o for the err_o cycle and drops to lowest priority.
          last_d  = sel_q;
          err_d   = 1'b1;
          state_d = ARB_IDLE;
        end else if ((state_q == ARB_ISSUE) && res_ready_i) begin
          state_d = ARB_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    grant_d = (state_d != ARB_IDLE) ? onehot4(sel_d) : '0;
    valid_d = (state_d == ARB_ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign grant_o     = grant_q;
  assign sel_o       = sel_q;
  assign res_valid_o = valid_q;
  assign err_o       = err_q;

endmodule
